// File: rtl/id_ex_alu_issue_pkg.sv
// Shared types for the ID/EX ALU issue slice: ALU control codes, RV32I opcodes,
// funct3 constants, immediate formats and the registered EX-side bundle.
package id_ex_alu_issue_pkg;

  localparam int unsigned ID_EX_XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10,
    B_BNE    = 4'd11,
    B_BLT    = 4'd12,
    B_BGE    = 4'd13,
    B_LTU    = 4'd14,
    B_GEU    = 4'd15
  } alu_op_t;

  typedef enum logic [6:0] {
    OP     = 7'b0110011,
    OP_IMM = 7'b0010011,
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011
  } opcode_t;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_t;

  typedef struct packed {
    logic                  valid;
    alu_op_t               alu_control;
    logic [ID_EX_XLEN-1:0] left;
    logic [ID_EX_XLEN-1:0] right;
    logic [ID_EX_XLEN-1:0] pc;
    logic [4:0]            rd;
    logic                  reg_write;
    logic                  is_branch;
    logic                  illegal;
  } id_ex_alu_t;

  // alt selects SUB/SRA on the funct7[5] variants; other funct3 values ignore it.
  function automatic alu_op_t arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic id_ex_alu_t bubble(input logic [ID_EX_XLEN-1:0] pc);
    id_ex_alu_t b;
    b             = '0;
    b.alu_control = ALU_ADD;
    b.pc          = pc;
    return b;
  endfunction

endpackage

// File: rtl/id_ex_alu_issue_alu_imm_gen.sv
// Combinational RV32I immediate generator: sign-extended I/S/B/U/J immediates
// selected by format. Opcode bits are not needed, so only instr[31:7] enters.
module alu_imm_gen
  import id_ex_alu_issue_pkg::*;
(
  input  logic [31:7] i_instr,
  input  imm_fmt_t    i_fmt,
  output logic [31:0] o_imm
);

  always_comb begin
    o_imm = '0;
    case (i_fmt)
      IMM_I: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S: o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B: o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U: o_imm = {i_instr[31:12], 12'b0};
      IMM_J: o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                      i_instr[20], i_instr[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// Decode-side ALU issue: decodes an RV32I instruction into ALU control and operands
// and registers them into the ID/EX stage with stall, flush and illegal flagging.
module id_ex_alu_issue
  import id_ex_alu_issue_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic            stall,
  input  logic            flush,
  output logic            ex_valid,
  output logic [3:0]      ex_alu_control,
  output logic [XLEN-1:0] ex_left_operand,
  output logic [XLEN-1:0] ex_right_operand,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_is_branch,
  output logic            ex_illegal
);

  opcode_t     w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_rd;
  imm_fmt_t    w_fmt;
  logic [31:0] w_imm;
  logic        w_illegal;
  id_ex_alu_t  w_dec;
  id_ex_alu_t  r_ex;

  assign w_opc = opcode_t'(id_instr[6:0]);
  assign w_f3  = id_instr[14:12];
  assign w_f7  = id_instr[31:25];
  assign w_rd  = id_instr[11:7];

  // Format select kept in its own block so the immediate path has no comb loop.
  always_comb begin
    w_fmt = IMM_I;
    case (w_opc)
      LUI, AUIPC: w_fmt = IMM_U;
      JAL:        w_fmt = IMM_J;
      BRANCH:     w_fmt = IMM_B;
      STORE:      w_fmt = IMM_S;
      default:    w_fmt = IMM_I;
    endcase
  end

  alu_imm_gen u_imm_gen (
    .i_instr (id_instr[31:7]),
    .i_fmt   (w_fmt),
    .o_imm   (w_imm)
  );

  always_comb begin
    w_illegal         = 1'b0;
    w_dec             = '0;
    w_dec.valid       = 1'b1;
    w_dec.alu_control = ALU_ADD;
    w_dec.pc          = id_pc;
    case (w_opc)
      OP: begin
        w_dec.left      = id_rs1_data;
        w_dec.right     = id_rs2_data;
        w_dec.reg_write = 1'b1;
        if (w_f7 == 7'h00)
          w_dec.alu_control = arith_op(w_f3, 1'b0);
        else if (w_f7 == 7'h20 && (w_f3 == F3_ADD || w_f3 == F3_SR))
          w_dec.alu_control = arith_op(w_f3, 1'b1);
        else
          w_illegal = 1'b1;
      end
      OP_IMM: begin
        w_dec.left        = id_rs1_data;
        w_dec.right       = w_imm;
        w_dec.reg_write   = 1'b1;
        w_dec.alu_control = arith_op(w_f3, 1'b0);
        if (w_f3 == F3_SLL || w_f3 == F3_SR) begin
          w_dec.right = {27'b0, id_instr[24:20]};
          if (w_f7 == 7'h20 && w_f3 == F3_SR)
            w_dec.alu_control = ALU_SRA;
          else if (w_f7 != 7'h00)
            w_illegal = 1'b1;
        end
      end
      LUI: begin
        w_dec.alu_control = ALU_LUI;
        w_dec.right       = w_imm;
        w_dec.reg_write   = 1'b1;
      end
      AUIPC: begin
        w_dec.left      = id_pc;
        w_dec.right     = w_imm;
        w_dec.reg_write = 1'b1;
      end
      JAL, JALR: begin
        w_dec.left      = id_pc;
        w_dec.right     = 32'd4;
        w_dec.reg_write = 1'b1;
        if (w_opc == JALR && w_f3 != 3'b000)
          w_illegal = 1'b1;
      end
      BRANCH: begin
        w_dec.left      = id_rs1_data;
        w_dec.right     = id_rs2_data;
        w_dec.is_branch = 1'b1;
        case (w_f3)
          F3_BEQ:  w_dec.alu_control = ALU_SUB;
          F3_BNE:  w_dec.alu_control = B_BNE;
          F3_BLT:  w_dec.alu_control = B_BLT;
          F3_BGE:  w_dec.alu_control = B_BGE;
          F3_BLTU: w_dec.alu_control = B_LTU;
          F3_BGEU: w_dec.alu_control = B_GEU;
          default: w_illegal = 1'b1;
        endcase
      end
      LOAD: begin
        w_dec.left      = id_rs1_data;
        w_dec.right     = w_imm;
        w_dec.reg_write = 1'b1;
        if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111)
          w_illegal = 1'b1;
      end
      STORE: begin
        w_dec.left  = id_rs1_data;
        w_dec.right = w_imm;
        if (w_f3 > 3'b010)
          w_illegal = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase

    if (w_dec.reg_write && w_rd != 5'd0)
      w_dec.rd = w_rd;
    else
      w_dec.reg_write = 1'b0;

    // Illegal instructions still issue as valid so the trap is taken downstream.
    if (w_illegal) begin
      w_dec         = bubble(id_pc);
      w_dec.valid   = 1'b1;
      w_dec.illegal = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      r_ex <= bubble(RESET_PC);
    else if (flush)
      r_ex <= bubble(r_ex.pc);
    else if (!stall)
      r_ex <= id_valid ? w_dec : bubble(r_ex.pc);
  end

  assign ex_valid         = r_ex.valid;
  assign ex_alu_control   = r_ex.alu_control;
  assign ex_left_operand  = r_ex.left;
  assign ex_right_operand = r_ex.right;
  assign ex_pc            = r_ex.pc;
  assign ex_rd            = r_ex.rd;
  assign ex_reg_write     = r_ex.reg_write;
  assign ex_is_branch     = r_ex.is_branch;
  assign ex_illegal       = r_ex.illegal;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed bench for id_ex_alu_issue: hand-encoded RV32I words with hand-computed
// expected EX bundles, plus stall/flush/reset ordering.
module tb_id_ex_alu_issue;
  import id_ex_alu_issue_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        reset_n, id_valid, stall, flush;
  logic [31:0] id_instr, id_pc, id_rs1_data, id_rs2_data;
  logic        ex_valid, ex_reg_write, ex_is_branch, ex_illegal;
  logic [3:0]  ex_alu_control;
  logic [31:0] ex_left_operand, ex_right_operand, ex_pc;
  logic [4:0]  ex_rd;

  int unsigned checks = 0;
  int unsigned errors = 0;
  id_ex_alu_t  got, exp_v;

  always #5 clk = ~clk;

  id_ex_alu_issue #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .id_valid         (id_valid),
    .id_instr         (id_instr),
    .id_pc            (id_pc),
    .id_rs1_data      (id_rs1_data),
    .id_rs2_data      (id_rs2_data),
    .stall            (stall),
    .flush            (flush),
    .ex_valid         (ex_valid),
    .ex_alu_control   (ex_alu_control),
    .ex_left_operand  (ex_left_operand),
    .ex_right_operand (ex_right_operand),
    .ex_pc            (ex_pc),
    .ex_rd            (ex_rd),
    .ex_reg_write     (ex_reg_write),
    .ex_is_branch     (ex_is_branch),
    .ex_illegal       (ex_illegal)
  );

  function automatic id_ex_alu_t mk(input logic v, input alu_op_t c, input logic [31:0] l,
                                    input logic [31:0] r, input logic [31:0] pc,
                                    input logic [4:0] rd, input logic wr, input logic br,
                                    input logic ill);
    id_ex_alu_t t;
    t = '{valid: v, alu_control: c, left: l, right: r, pc: pc, rd: rd,
          reg_write: wr, is_branch: br, illegal: ill};
    return t;
  endfunction

  function automatic id_ex_alu_t observe();
    id_ex_alu_t t;
    t = '{valid: ex_valid, alu_control: alu_op_t'(ex_alu_control), left: ex_left_operand,
          right: ex_right_operand, pc: ex_pc, rd: ex_rd, reg_write: ex_reg_write,
          is_branch: ex_is_branch, illegal: ex_illegal};
    return t;
  endfunction

  // Reference ALU: result is zero exactly when a branch op is taken.
  function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    case (c)
      4'(ALU_SUB): return a - b;
      4'(B_BNE):   return (a != b) ? 32'd0 : 32'd1;
      default:     return a + b;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    id_valid    = 1'b1;
    id_instr    = instr;
    id_pc       = pc;
    id_rs1_data = rs1;
    id_rs2_data = rs2;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    issue(32'h00500093, 32'h40, 32'h1, 32'h2);
    step();
    got = observe(); exp_v = mk(1'b0, ALU_ADD, '0, '0, RST_PC, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL reset: got %h exp %h", got, exp_v); end
    reset_n = 1'b1;
  endtask

  task automatic test_addi();
    issue(32'h00500093, 32'h100, 32'h0, 32'h55);
    got = observe(); exp_v = mk(1'b1, ALU_ADD, 32'd0, 32'd5, 32'h100, 5'd1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL addi: got %h exp %h", got, exp_v); end
  endtask

  task automatic test_sub();
    issue(32'h40208133, 32'h104, 32'd9, 32'd4);
    got = observe(); exp_v = mk(1'b1, ALU_SUB, 32'd9, 32'd4, 32'h104, 5'd2, 1'b1, 1'b0, 1'b0);
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL sub: got %h exp %h", got, exp_v); end
    checks++;
    if (alu_ref(ex_alu_control, ex_left_operand, ex_right_operand) !== 32'd5) begin
      errors++;
      $display("FAIL sub_result: got %0d exp 5",
               alu_ref(ex_alu_control, ex_left_operand, ex_right_operand));
    end
  endtask

  task automatic test_branch();
    issue(32'h00209463, 32'h108, 32'd3, 32'd7);
    got = observe(); exp_v = mk(1'b1, B_BNE, 32'd3, 32'd7, 32'h108, 5'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL bne: got %h exp %h", got, exp_v); end
    checks++;
    if ((alu_ref(ex_alu_control, ex_left_operand, ex_right_operand) == 32'd0) !== 1'b1) begin
      errors++; $display("FAIL bne_zero_flag: got 0 exp 1");
    end
  endtask

  task automatic test_stall_flush();
    issue(32'h123452B7, 32'h200, 32'hDEAD, 32'hBEEF);
    exp_v = mk(1'b1, ALU_LUI, 32'd0, 32'h12345000, 32'h200, 5'd5, 1'b1, 1'b0, 1'b0);
    got = observe();
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL lui: got %h exp %h", got, exp_v); end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      issue(32'h00500093, 32'h204 + 32'(4 * i), 32'h7, 32'h8);
      got = observe();
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL stall_hold%0d: got %h exp %h", i, got, exp_v); end
    end
    stall = 1'b0;
    flush = 1'b1;
    issue(32'h00500093, 32'h20C, 32'h7, 32'h8);
    flush = 1'b0;
    got = observe(); exp_v = mk(1'b0, ALU_ADD, '0, '0, 32'h200, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL flush: got %h exp %h", got, exp_v); end
  endtask

  task automatic test_illegal();
    issue(32'hFFFFFFFF, 32'h300, 32'h11, 32'h22);
    got = observe(); exp_v = mk(1'b1, ALU_ADD, '0, '0, 32'h300, 5'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL illegal_all_ones: got %h exp %h", got, exp_v); end
    issue(32'h20315093, 32'h304, 32'h80000000, 32'h0);
    got = observe(); exp_v = mk(1'b1, ALU_ADD, '0, '0, 32'h304, 5'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL srai_bad_imm: got %h exp %h", got, exp_v); end
    issue(32'h40315093, 32'h308, 32'h80000000, 32'h0);
    got = observe(); exp_v = mk(1'b1, ALU_SRA, 32'h80000000, 32'd3, 32'h308, 5'd1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL srai_ok: got %h exp %h", got, exp_v); end
    issue(32'h0000A463, 32'h30C, 32'h1, 32'h1);
    got = observe(); exp_v = mk(1'b1, ALU_ADD, '0, '0, 32'h30C, 5'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL branch_f3_010: got %h exp %h", got, exp_v); end
  endtask

  task automatic test_back_to_back();
    issue(32'h00001197, 32'h400, 32'h1, 32'h2);
    got = observe(); exp_v = mk(1'b1, ALU_ADD, 32'h400, 32'h1000, 32'h400, 5'd3, 1'b1, 1'b0, 1'b0);
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL auipc: got %h exp %h", got, exp_v); end
    issue(32'h008000EF, 32'h404, 32'h1, 32'h2);
    got = observe(); exp_v = mk(1'b1, ALU_ADD, 32'h404, 32'd4, 32'h404, 5'd1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL jal: got %h exp %h", got, exp_v); end
    issue(32'h0020A423, 32'h408, 32'h1000, 32'h99);
    got = observe(); exp_v = mk(1'b1, ALU_ADD, 32'h1000, 32'd8, 32'h408, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL sw: got %h exp %h", got, exp_v); end
    issue(32'hFFC0A203, 32'h40C, 32'h1000, 32'h99);
    got = observe(); exp_v = mk(1'b1, ALU_ADD, 32'h1000, 32'hFFFFFFFC, 32'h40C, 5'd4, 1'b1, 1'b0, 1'b0);
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL lw_neg: got %h exp %h", got, exp_v); end
    issue(32'h00100013, 32'h410, 32'h0, 32'h0);
    got = observe(); exp_v = mk(1'b1, ALU_ADD, 32'd0, 32'd1, 32'h410, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL addi_rd0: got %h exp %h", got, exp_v); end
    id_valid = 1'b0;
    id_pc    = 32'h414;
    step();
    got = observe(); exp_v = mk(1'b0, ALU_ADD, '0, '0, 32'h410, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL id_invalid_bubble: got %h exp %h", got, exp_v); end
  endtask

  task automatic test_priority();
    issue(32'h00500093, 32'h500, 32'h0, 32'h0);
    stall = 1'b1;
    flush = 1'b1;
    issue(32'h40208133, 32'h504, 32'd9, 32'd4);
    got = observe(); exp_v = mk(1'b0, ALU_ADD, '0, '0, 32'h500, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL stall_flush: got %h exp %h", got, exp_v); end
    flush = 1'b0;
    stall = 1'b0;
    issue(32'h40208133, 32'h508, 32'd9, 32'd4);
    stall   = 1'b1;
    reset_n = 1'b0;
    issue(32'h00500093, 32'h50C, 32'h0, 32'h0);
    got = observe(); exp_v = mk(1'b0, ALU_ADD, '0, '0, RST_PC, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL reset_mid_stall: got %h exp %h", got, exp_v); end
    reset_n = 1'b1;
    stall   = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    id_instr = '0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0;
    test_reset();
    test_addi();
    test_sub();
    test_branch();
    test_stall_flush();
    test_illegal();
    test_back_to_back();
    test_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
